// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the stall/flush controller: state
// encoding, the bubble-count width and the register-match helper.
package hazard_stall_ctrl_pkg;

  localparam int         BUB_W    = 2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } stateT;

  // A destination register hits the ID instruction's sources; r0 never does.
  function automatic logic regMatch(input logic [4:0] r,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       useRt);
    return (r != REG_ZERO) && ((r == rs) || (useRt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of hazard-relevant pipeline fields (into the controller) and the
// pipeline-register control pins (out of the controller).
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);

  logic [4:0]       IF_ID_RegRs;
  logic [4:0]       IF_ID_RegRt;
  logic             IF_ID_UseRt;
  logic             ID_Branch;
  logic             BranchTaken;
  logic             ID_EX_MemRead;
  logic             ID_EX_RegWr;
  logic [4:0]       ID_EX_RegRd;
  logic             EX_MEM_MemRead;
  logic [4:0]       EX_MEM_RegRd;
  logic             DMem_Busy;
  logic             PC_Wr;
  logic             IF_ID_Wr;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             Pipe_Freeze;
  logic [CNT_W-1:0] Bubble_Cnt;

  modport master (
    output IF_ID_RegRs, IF_ID_RegRt, IF_ID_UseRt, ID_Branch, BranchTaken,
           ID_EX_MemRead, ID_EX_RegWr, ID_EX_RegRd, EX_MEM_MemRead,
           EX_MEM_RegRd, DMem_Busy,
    input  PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze, Bubble_Cnt
  );

  modport slave (
    input  IF_ID_RegRs, IF_ID_RegRt, IF_ID_UseRt, ID_Branch, BranchTaken,
           ID_EX_MemRead, ID_EX_RegWr, ID_EX_RegRd, EX_MEM_MemRead,
           EX_MEM_RegRd, DMem_Busy,
    output PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze, Bubble_Cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational count of bubbles needed for RAW hazards that forwarding
// cannot resolve in time; the first matching rule wins.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [4:0]       ifIdRs,
  input  logic [4:0]       ifIdRt,
  input  logic             ifIdUseRt,
  input  logic             idBranch,
  input  logic             idExMemRead,
  input  logic             idExRegWr,
  input  logic [4:0]       idExRd,
  input  logic             exMemMemRead,
  input  logic [4:0]       exMemRd,
  output logic [BUB_W-1:0] bubbles
);

  logic exHit;
  logic memHit;

  assign exHit  = regMatch(idExRd,  ifIdRs, ifIdRt, ifIdUseRt);
  assign memHit = regMatch(exMemRd, ifIdRs, ifIdRt, ifIdUseRt);

  // Prioritised rule table: load feeding a branch needs the longest wait.
  always_comb begin
    bubbles = '0;
    if (idExMemRead && idBranch && exHit)
      bubbles = 2'd2;
    else if (idExMemRead && exHit)
      bubbles = 2'd1;
    else if (idBranch && idExRegWr && exHit)
      bubbles = 2'd1;
    else if (idBranch && exMemMemRead && memHit)
      bubbles = 2'd1;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: inserts counted bubbles for unforwardable hazards,
// flushes IF/ID on taken branches and freezes the pipe on data-memory wait.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_ctrl_if.slave bus
);

  stateT             state, stateNext;
  stateT             retState, retStateNext;
  stateT             effState;
  logic [BUB_W-1:0]  rem, remNext;
  logic [BUB_W-1:0]  bubbles;
  logic [CNT_W-1:0]  bubbleCnt;
  logic              runHazard;
  logic              bubble;

  hazard_detect uDetect (
    .ifIdRs       (bus.IF_ID_RegRs),
    .ifIdRt       (bus.IF_ID_RegRt),
    .ifIdUseRt    (bus.IF_ID_UseRt),
    .idBranch     (bus.ID_Branch),
    .idExMemRead  (bus.ID_EX_MemRead),
    .idExRegWr    (bus.ID_EX_RegWr),
    .idExRd       (bus.ID_EX_RegRd),
    .exMemMemRead (bus.EX_MEM_MemRead),
    .exMemRd      (bus.EX_MEM_RegRd),
    .bubbles      (bubbles)
  );

  // Leaving FREEZE acts as the saved state in that same cycle.
  assign effState  = (state == ST_FREEZE) ? retState : state;
  assign runHazard = (effState == ST_RUN) && (bubbles != '0);
  assign bubble    = rst_n && !bus.DMem_Busy &&
                     ((effState == ST_STALL) || runHazard);

  // State, remaining bubbles and the saturating bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      retState  <= ST_RUN;
      rem       <= '0;
      bubbleCnt <= '0;
    end else begin
      state    <= stateNext;
      retState <= retStateNext;
      rem      <= remNext;
      if (bubble && (bubbleCnt != '1))
        bubbleCnt <= bubbleCnt + CNT_W'(1);
    end
  end

  // Next-state: busy memory parks everything, otherwise run the bubble count.
  always_comb begin
    stateNext    = state;
    retStateNext = retState;
    remNext      = rem;
    if (bus.DMem_Busy) begin
      if (state != ST_FREEZE)
        retStateNext = state;
      stateNext = ST_FREEZE;
    end else begin
      case (effState)
        ST_RUN: begin
          stateNext = ST_RUN;
          if (bubbles != '0) begin
            remNext = bubbles - 2'd1;
            if ((bubbles - 2'd1) != 2'd0)
              stateNext = ST_STALL;
          end
        end
        ST_STALL: begin
          remNext   = rem - 2'd1;
          stateNext = (rem == 2'd1) ? ST_RUN : ST_STALL;
        end
        default: stateNext = ST_RUN;
      endcase
    end
  end

  // Pipeline-register control decode, reset first, then freeze, then bubble.
  always_comb begin
    bus.PC_Wr       = 1'b1;
    bus.IF_ID_Wr    = 1'b1;
    bus.IF_ID_Flush = 1'b0;
    bus.ID_EX_Flush = 1'b0;
    bus.Pipe_Freeze = 1'b0;
    if (!rst_n) begin
      bus.PC_Wr       = 1'b0;
      bus.IF_ID_Wr    = 1'b0;
      bus.IF_ID_Flush = 1'b1;
      bus.ID_EX_Flush = 1'b1;
    end else if (bus.DMem_Busy) begin
      bus.PC_Wr       = 1'b0;
      bus.IF_ID_Wr    = 1'b0;
      bus.Pipe_Freeze = 1'b1;
    end else if (bubble) begin
      bus.PC_Wr       = 1'b0;
      bus.IF_ID_Wr    = 1'b0;
      bus.ID_EX_Flush = 1'b1;
    end else begin
      bus.IF_ID_Flush = bus.BranchTaken;
    end
  end

  assign bus.Bubble_Cnt = bubbleCnt;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Stall and flush controller for the 5-stage pipeline: the producer-side complement to the EX/ID forwarding units. It detects RAW hazards that forwarding cannot cover (load-use, and branch operands not yet available in ID) and inserts a counted number of bubbles. It also handles taken-branch flushes and whole-pipe freezes on data-memory wait, and drives the write-enable/flush pins of PC, IF/ID and ID/EX.

## Interface
Parameters:
- CNT_W, 16, width of the saturating bubble performance counter

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- IF_ID_RegRs  in  5  rs of the instruction in ID
- IF_ID_RegRt  in  5  rt of the instruction in ID
- IF_ID_UseRt  in  1  ID instruction reads rt as a source
- ID_Branch  in  1  ID instruction compares/uses operands in ID (beq/bne/jr)
- BranchTaken  in  1  branch/jump in ID resolved taken
- ID_EX_MemRead  in  1  EX instruction is a load
- ID_EX_RegWr  in  1  EX instruction writes a register
- ID_EX_RegRd  in  5  EX destination register (already muxed rt/rd)
- EX_MEM_MemRead  in  1  MEM instruction is a load
- EX_MEM_RegRd  in  5  MEM destination register
- DMem_Busy  in  1  data memory not ready this cycle
- PC_Wr  out  1  PC write enable
- IF_ID_Wr  out  1  IF/ID write enable
- IF_ID_Flush  out  1  load NOP into IF/ID
- ID_EX_Flush  out  1  load bubble into ID/EX
- Pipe_Freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- Bubble_Cnt  out  CNT_W  bubbles inserted since reset, saturating

## Operation
- Match(r) = r != 0 && (r == IF_ID_RegRs || (IF_ID_UseRt && r == IF_ID_RegRt)).
- Required bubbles B, evaluated in RUN only, first match wins:
  - ID_EX_MemRead && ID_Branch && Match(ID_EX_RegRd): B=2.
  - ID_EX_MemRead && Match(ID_EX_RegRd): B=1.
  - ID_Branch && ID_EX_RegWr && Match(ID_EX_RegRd): B=1.
  - ID_Branch && EX_MEM_MemRead && Match(EX_MEM_RegRd): B=1.
  - Otherwise B=0.
- State machine: RUN, STALL, FREEZE. 2-bit remaining-bubble counter `rem`.
  - RUN, B>0: this cycle is a bubble. rem <= B-1. Go to STALL if B-1>0, else stay in RUN.
  - STALL: bubble cycle. rem decrements; at rem==1 return to RUN. Hazard detection is ignored.
  - Any state with DMem_Busy=1: go to FREEZE (saving return state and rem); all state holds.
  - FREEZE with DMem_Busy=0: resume in the saved state. The first cycle back is evaluated normally.
- Outputs, priority top-down:
  - Reset asserted: PC_Wr=0, IF_ID_Wr=0, IF_ID_Flush=1, ID_EX_Flush=1, Pipe_Freeze=0, Bubble_Cnt=0.
  - DMem_Busy=1: PC_Wr=0, IF_ID_Wr=0, Pipe_Freeze=1, both flushes 0.
  - Bubble cycle (RUN with B>0, or STALL): PC_Wr=0, IF_ID_Wr=0, ID_EX_Flush=1, IF_ID_Flush=0. BranchTaken is ignored.
  - RUN, B=0: PC_Wr=1, IF_ID_Wr=1, ID_EX_Flush=0, IF_ID_Flush=BranchTaken.
- Bubble_Cnt increments by 1 on every bubble cycle and saturates at all-ones. It does not count freeze cycles.

## Timing
- Detection-to-stall is combinational (Mealy). The stalled instruction never advances out of ID on the detection cycle.
- The state register, rem and Bubble_Cnt update on posedge clk and clear asynchronously on negedge rst_n. After reset release, the controller starts in RUN with rem=0.
- A B=2 hazard gives exactly 2 consecutive bubble cycles, excluding interleaved freeze cycles.
- Deassertion of reset mid-stall is not possible: reset clears all state, so any pending bubbles are discarded.
- DMem_Busy and a new hazard in the same cycle: the freeze wins. The hazard is re-evaluated on the first non-busy cycle.

## Structure
- Shared pipeline package holds:
  - state encoding constants ST_RUN=2'd0, ST_STALL=2'd1, ST_FREEZE=2'd2;
  - the REG_ZERO=5'd0 constant;
  - the bubble-count width (2).
- One natural sub-module: hazard_detect, the combinational B calculation. The FSM, counters and output decode stay in the top.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_RegRd=5, IF_ID_RegRs=5, ID_Branch=0 -> one cycle PC_Wr=0/ID_EX_Flush=1, then PC_Wr=1; Bubble_Cnt=1.
- Load-branch: same with ID_Branch=1 -> two bubble cycles, then RUN; Bubble_Cnt=2. Repeat with ID_EX_RegRd=0 -> no stall.
- ALU-branch: ID_EX_RegWr=1, RegRd=7, IF_ID_RegRt=7, UseRt=1, ID_Branch=1 -> 1 bubble. With UseRt=0 -> no stall.
- Taken branch, no hazard: BranchTaken=1 -> IF_ID_Flush=1, PC_Wr=1 for one cycle. Taken branch during a bubble -> IF_ID_Flush=0.
- Freeze mid-stall: B=2 detected, then DMem_Busy=1 for 3 cycles on the second bubble -> Pipe_Freeze=1 for 3 cycles, then the remaining bubble, then RUN; Bubble_Cnt=2.
- Reset: assert rst_n=0 during STALL -> outputs immediately take their reset values; after release, RUN with Bubble_Cnt=0. Saturation: preload via 2^CNT_W bubbles (CNT_W=4 build) -> Bubble_Cnt holds at 15.
